ser_rx_8: RTL and testbench
===========================

Name: ser_rx_8

Overview:
Serial-to-parallel receiver for the right-shifting serial link. It is the receiving end for a parallel-load, LSB-first shift register whose Shift_Out feeds this block's Shift_In. It collects WIDTH bits, LSB first, one per Shift_En strobe after a Start, then presents the assembled word with a Valid/Ack handshake. It sits between the serial datapath and the register/display logic that consumes whole bytes.

Parameters:
WIDTH, 8, word length in bits; must be at least 2.

Ports:
Clk  input  1  system clock; all state updates on rising edge.
Reset  input  1  asynchronous, active-high reset.
Start  input  1  begin a new frame; sampled only in IDLE.
Shift_En  input  1  bit strobe; Shift_In is valid when this is high.
Shift_In  input  1  serial data, LSB of the word first.
Ack  input  1  consumer accepts Data_out; clears Valid.
Data_out  output  WIDTH  last completed word; held stable while Valid=1.
Valid  output  1  Data_out holds an unacknowledged word.
Busy  output  1  frame in progress (state SHIFT).
Overrun  output  1  sticky; a word completed while the previous word was still unacknowledged.
Bit_Count  output  $clog2(WIDTH)+1  bits accepted in the current frame.

Behaviour:
- Reset (asynchronous, active-high, any time including mid-frame):
  - state=IDLE; shift register=0; Data_out=0; Valid=0; Busy=0; Overrun=0; Bit_Count=0.
  - A partial frame is discarded.
- States: IDLE and SHIFT. Busy=1 exactly when state=SHIFT (registered state decode).
- IDLE:
  - Start=1 at an edge: shift register<=0, Bit_Count<=0, state<=SHIFT.
  - Shift_En is ignored in IDLE, including in the same cycle as Start.
  - Start=0: no change.
- SHIFT:
  - Start is ignored.
  - Each edge with Shift_En=1: shreg <= {Shift_In, shreg[WIDTH-1:1]} and Bit_Count++. The first received bit therefore ends in bit 0.
  - Shift_En=0: hold. Gaps between strobes are unlimited.
- Completion: on the edge that accepts the WIDTH-th bit:
  - Data_out <= {Shift_In, shreg[WIDTH-1:1]}, loaded in the same edge, so there is zero extra latency.
  - Valid<=1, Bit_Count<=0, state<=IDLE.
  - Valid and Data_out are visible in the cycle after that edge.
- Handshake:
  - Edge with Valid=1 and Ack=1: Valid<=0; Data_out holds its value.
  - Ack while Valid=0 is ignored.
  - Data_out changes only at completion or reset.
- Simultaneous completion and Ack: completion wins. Valid stays 1 with the new word. Overrun is not set, because the old word was accepted.
- Overrun:
  - Set when completion occurs while Valid=1 and Ack=0. The new word overwrites Data_out and Valid stays 1.
  - Cleared at an edge with Ack=1, unless the same edge sets it.
  - Set has priority.
- A new frame may be started while Valid=1 (double-buffered: the shift register and Data_out are separate).
- Bit_Count never exceeds WIDTH-1 when observed. It reads 0 in IDLE.

Test Plan:
1. Reset; Start pulse; then 8 consecutive Shift_En with Shift_In = 1,0,1,0,0,1,0,1 -> after the 8th edge, Data_out=0xA5, Valid=1, Busy=0, Overrun=0. Ack for 1 cycle -> Valid=0 and Data_out stays 0xA5.
2. Start, then bits of 0x3C with 0–3 idle cycles between strobes, plus Shift_En=1 asserted in the Start cycle -> the Start-cycle strobe is ignored; Data_out=0x3C; Bit_Count steps 0..7 only on strobes.
3. Receive 0x11 (no Ack), then receive 0xF0 -> Data_out=0xF0, Valid=1, Overrun=1. Then Ack -> Valid=0, Overrun=0.
4. Valid=1 holding 0x11; receive 0x22 with Ack=1 on the completion edge -> Data_out=0x22, Valid=1, Overrun=0.
5. Start, 3 bits, assert Reset asynchronously between edges -> all outputs 0 immediately. Next full frame of 0x81 -> Data_out=0x81, with no residue from the aborted frame.
6. During SHIFT after 4 bits, pulse Start -> ignored; Bit_Count continues 4→7; word completes after 4 more strobes, matching the 8 sent bits.

Source files
------------

// File: rtl/ser_rx_8.sv
// Serial-to-parallel receiver: collects WIDTH bits LSB first after Start,
// then presents the word with a Valid/Ack handshake and sticky Overrun.
module ser_rx_8 #(
  parameter int WIDTH = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic                     Shift_En,
  input  logic                     Shift_In,
  input  logic                     Ack,
  output logic [WIDTH-1:0]         Data_out,
  output logic                     Valid,
  output logic                     Busy,
  output logic                     Overrun,
  output logic [$clog2(WIDTH):0]   Bit_Count
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             valid_q, valid_d;
  logic             ovr_q,   ovr_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] shifted;

  assign shifted = {Shift_In, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;

    // Ack is applied first so a same-edge completion can override it.
    if (Ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          shreg_d = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      default: begin
        if (Shift_En) begin
          shreg_d = shifted;
          if (cnt_q == LAST) begin
            data_d  = shifted;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
            if (valid_q && !Ack) ovr_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Data_out  = data_q;
  assign Valid     = valid_q;
  assign Busy      = (state_q == S_SHIFT);
  assign Overrun   = ovr_q;
  assign Bit_Count = cnt_q;

endmodule

// File: tb/tb_ser_rx_8.sv
// Directed bench for ser_rx_8: frames, gaps, overrun, Ack races, async reset.
module tb_ser_rx_8;
  logic       Clk = 1'b0;
  logic       Reset, Start, Shift_En, Shift_In, Ack;
  logic [7:0] Data_out;
  logic       Valid, Busy, Overrun;
  logic [3:0] Bit_Count;
  int n_chk = 0;
  int n_fail = 0;

  ser_rx_8 #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Shift_En(Shift_En),
    .Shift_In(Shift_In), .Ack(Ack), .Data_out(Data_out), .Valid(Valid),
    .Busy(Busy), .Overrun(Overrun), .Bit_Count(Bit_Count)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_frame(input logic en);
    Start = 1'b1; Shift_En = en; Shift_In = 1'b1;
    tick();
    Start = 1'b0; Shift_En = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] w, input int lo, input int hi, input logic ack_last);
    for (int i = lo; i <= hi; i++) begin
      Shift_En = 1'b1; Shift_In = w[i];
      Ack = (i == 7) ? ack_last : 1'b0;
      tick();
    end
    Shift_En = 1'b0; Ack = 1'b0;
  endtask

  task automatic ack_pulse();
    Ack = 1'b1; tick(); Ack = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Start = 0; Shift_En = 0; Shift_In = 0; Ack = 0;
    #12;
    chk("rst_data", Data_out, 0);
    chk("rst_valid", Valid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_ovr", Overrun, 0);
    chk("rst_cnt", Bit_Count, 0);
    Reset = 1'b0;
    tick();

    // 1: 0xA5 back to back
    start_frame(1'b0);
    chk("t1_busy", Busy, 1);
    send_bits(8'hA5, 0, 7, 1'b0);
    chk("t1_data", Data_out, 8'hA5);
    chk("t1_valid", Valid, 1);
    chk("t1_busy_done", Busy, 0);
    chk("t1_ovr", Overrun, 0);
    chk("t1_cnt", Bit_Count, 0);
    ack_pulse();
    chk("t1_ack_valid", Valid, 0);
    chk("t1_ack_data", Data_out, 8'hA5);
    ack_pulse();
    chk("t1_ack_idle", Valid, 0);

    // 2: 0x3C with gaps, strobe in Start cycle ignored
    start_frame(1'b1);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < i % 4; g++) tick();
      chk("t2_cnt", Bit_Count, i);
      send_bits(8'h3C, i, i, 1'b0);
    end
    chk("t2_data", Data_out, 8'h3C);
    chk("t2_valid", Valid, 1);
    ack_pulse();

    // 3: overrun
    start_frame(1'b0); send_bits(8'h11, 0, 7, 1'b0);
    chk("t3_first", Data_out, 8'h11);
    chk("t3_first_ovr", Overrun, 0);
    start_frame(1'b0); send_bits(8'hF0, 0, 7, 1'b0);
    chk("t3_data", Data_out, 8'hF0);
    chk("t3_valid", Valid, 1);
    chk("t3_ovr", Overrun, 1);
    ack_pulse();
    chk("t3_ack_valid", Valid, 0);
    chk("t3_ack_ovr", Overrun, 0);

    // 4: completion with simultaneous Ack
    start_frame(1'b0); send_bits(8'h11, 0, 7, 1'b0);
    start_frame(1'b0); send_bits(8'h22, 0, 7, 1'b1);
    chk("t4_data", Data_out, 8'h22);
    chk("t4_valid", Valid, 1);
    chk("t4_ovr", Overrun, 0);

    // 5: async reset mid-frame (Valid still 1 from previous test)
    start_frame(1'b0); send_bits(8'hFF, 0, 2, 1'b0);
    chk("t5_pre_cnt", Bit_Count, 3);
    #2 Reset = 1'b1;
    #1;
    chk("t5_rst_data", Data_out, 0);
    chk("t5_rst_valid", Valid, 0);
    chk("t5_rst_busy", Busy, 0);
    chk("t5_rst_cnt", Bit_Count, 0);
    Reset = 1'b0;
    tick();
    start_frame(1'b0); send_bits(8'h81, 0, 7, 1'b0);
    chk("t5_data", Data_out, 8'h81);
    chk("t5_valid", Valid, 1);
    ack_pulse();

    // 6: Start ignored during SHIFT
    start_frame(1'b0); send_bits(8'h6B, 0, 3, 1'b0);
    Start = 1'b1; tick(); Start = 1'b0;
    chk("t6_cnt4", Bit_Count, 4);
    chk("t6_busy", Busy, 1);
    for (int i = 4; i < 8; i++) begin
      chk("t6_cnt", Bit_Count, i);
      send_bits(8'h6B, i, i, 1'b0);
    end
    chk("t6_data", Data_out, 8'h6B);
    chk("t6_valid", Valid, 1);
    chk("t6_busy_done", Busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
